// File: rtl/carry_save_adder_pkg.sv
// Shared definitions for the registered 3:2 carry-save compressor.
// The resolver function is used by the RTL and by any reference model,
// so both sides agree on how sum/carry combine into a single value.
package carry_save_pkg;

  // Operand width used when an instance does not override N.
  localparam int CSA_DEFAULT_WIDTH = 8;

  // Widest operand the shared resolver accepts. Callers zero-extend their
  // N-bit vectors to this width and truncate the result back to N+2 bits.
  localparam int CSA_MAX_WIDTH = 64;

  typedef logic [CSA_MAX_WIDTH-1:0] csa_vec_t;
  typedef logic [CSA_MAX_WIDTH+1:0] csa_total_t;

  // Resolve a sum/carry pair into a plain binary value. The carry vector is
  // unshifted (bit i carries weight 2^(i+1)), so it is shifted left by one
  // here. Two extra bits hold the worst case 3*(2^N-1) without wrapping.
  function automatic csa_total_t csa_total(input csa_vec_t sum,
                                           input csa_vec_t carry);
    csa_total_t sum_ext;
    csa_total_t carry_ext;
    sum_ext   = {2'b00, sum};
    carry_ext = {2'b00, carry};
    return sum_ext + (carry_ext << 1);
  endfunction

endpackage

// File: rtl/carry_save_adder_if.sv
// Operand/result bundle for carry_save_adder. The producer of operands
// uses the master modport; the compressor itself uses the slave modport.
interface carry_save_adder_if
  import carry_save_pkg::*;
#(
  parameter int N = CSA_DEFAULT_WIDTH
);

  // Operand side.
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] c;

  // Result side.
  logic         out_valid;
  logic [N-1:0] sum;
  logic [N-1:0] carry;
  logic [N+1:0] total;

  modport master (
    output in_valid, a, b, c,
    input  out_valid, sum, carry, total
  );

  modport slave (
    input  in_valid, a, b, c,
    output out_valid, sum, carry, total
  );

endinterface

// File: rtl/carry_save_adder_cell.sv
// One-bit full-adder cell: the building block of the 3:2 compressor.
// Purely combinational; the top level replicates it once per bit.
module csa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  // Parity of the three inputs gives the sum bit.
  assign s  = a ^ b ^ c;

  // Majority of the three inputs gives the carry bit.
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/carry_save_adder.sv
// Registered N-bit 3:2 carry-save compressor.
// Three operands are reduced bit-by-bit to a sum vector and an unshifted
// carry vector, and a resolved N+2-bit total is formed alongside them.
// Everything is captured in one register stage, so there is no
// combinational path from the operand side to the result side.
// N must lie in 1..CSA_MAX_WIDTH because the shared resolver works at
// that fixed width.
module carry_save_adder
  import carry_save_pkg::*;
#(
  parameter int N = CSA_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  carry_save_adder_if.slave  bus
);

  // Compressor outputs before the register stage.
  logic [N-1:0] sum_c;
  logic [N-1:0] carry_c;
  logic [N+1:0] total_c;

  // Registered results.
  logic         out_valid_q;
  logic [N-1:0] sum_q;
  logic [N-1:0] carry_q;
  logic [N+1:0] total_q;

  // One full-adder cell per bit position; no carry moves between
  // positions here, which is what keeps the stage one gate-level deep.
  for (genvar i = 0; i < N; i++) begin : g_cell
    csa_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .c  (bus.c[i]),
      .s  (sum_c[i]),
      .co (carry_c[i])
    );
  end

  // Resolve sum + (carry << 1) at N+2 bits so the total never wraps.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a value on every
    // path (here a single unconditional assignment), so no latch is inferred.
    total_c = (N+2)'(csa_total(CSA_MAX_WIDTH'(sum_c), CSA_MAX_WIDTH'(carry_c)));
  end

  // Result registers: load on valid operands, hold otherwise; out_valid
  // simply follows in_valid by one cycle. Reset clears everything at once,
  // which also discards an operand presented in the reset cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its inputs from before the clock edge.
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      total_q     <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q   <= sum_c;
        carry_q <= carry_c;
        total_q <= total_c;
      end
    end
  end

  // Drive the result side of the bundle straight from the registers.
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.total     = total_q;

endmodule

// File: tb/tb_carry_save_adder.sv
// Directed and short random checks for carry_save_adder (N = 8).
module tb_carry_save_adder;
  import carry_save_pkg::*;

  localparam int N = 8;

  logic clk;
  logic rst;

  int n_checks;
  int n_pass;

  carry_save_adder_if #(.N(N)) bus ();

  carry_save_adder #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Present one operand set at the falling edge, then sample #1 after the
  // following rising edge.
  task automatic drive(input logic v, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] c);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.c        = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v,
                           input int s, input int cy, input int t);
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(v));
    check({tag, ".sum"},       64'(bus.sum),       64'(s));
    check({tag, ".carry"},     64'(bus.carry),     64'(cy));
    check({tag, ".total"},     64'(bus.total),     64'(t));
  endtask

  initial begin
    logic [N-1:0] ra, rb, rc;
    logic [N-1:0] exp_s, exp_c;
    logic [N+1:0] exp_t;
    csa_total_t   model_t;

    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.c        = '0;

    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state", 1'b0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed results.
    drive(1'b1, 8'd0, 8'd0, 8'd0);
    check_out("zeros", 1'b1, 0, 0, 0);
    drive(1'b1, 8'd5, 8'd5, 8'd0);
    check_out("5_5_0", 1'b1, 0, 5, 10);
    drive(1'b1, 8'd5, 8'd5, 8'd5);
    check_out("5_5_5", 1'b1, 5, 5, 15);
    drive(1'b1, 8'd7, 8'd9, 8'd4);
    check_out("7_9_4", 1'b1, 10, 5, 20);
    drive(1'b1, 8'd255, 8'd255, 8'd0);
    check_out("ff_ff_0", 1'b1, 0, 255, 510);
    drive(1'b1, 8'd255, 8'd255, 8'd255);
    check_out("ff_ff_ff", 1'b1, 255, 255, 765);

    // Valid pulse 1,0,1: the gap must hold the previous result.
    drive(1'b1, 8'd3, 8'd6, 8'd12);
    check_out("pulse1", 1'b1, 9, 6, 21);
    drive(1'b0, 8'd1, 8'd1, 8'd1);
    check_out("gap_hold", 1'b0, 9, 6, 21);
    drive(1'b1, 8'd100, 8'd50, 8'd25);
    check_out("pulse2", 1'b1, 79, 48, 175);

    // Asynchronous reset in the middle of a valid stream.
    drive(1'b1, 8'd255, 8'd255, 8'd255);
    check_out("pre_reset", 1'b1, 255, 255, 765);
    @(negedge clk);
    bus.a = 8'd17;
    bus.b = 8'd34;
    bus.c = 8'd68;
    #2;
    rst = 1'b1;
    #1;
    check_out("reset_async", 1'b0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_out("reset_held", 1'b0, 0, 0, 0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_out("reset_discard", 1'b0, 0, 0, 0);

    // Back-to-back random operands; one result per cycle.
    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom_range(0, 255));
      rb = N'($urandom_range(0, 255));
      rc = N'($urandom_range(0, 255));
      if (i == 0) begin
        ra = 8'd255;
        rb = 8'd255;
        rc = 8'd255;
      end
      exp_s   = ra ^ rb ^ rc;
      exp_c   = (ra & rb) | (ra & rc) | (rb & rc);
      exp_t   = (N+2)'(ra) + (N+2)'(rb) + (N+2)'(rc);
      model_t = csa_total(CSA_MAX_WIDTH'(exp_s), CSA_MAX_WIDTH'(exp_c));
      drive(1'b1, ra, rb, rc);
      check("stream.out_valid", 64'(bus.out_valid), 64'd1);
      check("stream.sum",       64'(bus.sum),       64'(exp_s));
      check("stream.carry",     64'(bus.carry),     64'(exp_c));
      check("stream.total_abc", 64'(bus.total),     64'(exp_t));
      check("stream.total_fn",  64'(bus.total),     64'(model_t));
    end

    drive(1'b0, 8'd0, 8'd0, 8'd0);
    check("stream_end.out_valid", 64'(bus.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
